shift_seq_ctrl: RTL

Command sequencer for the `ShiftParallel_NBIT` universal shift register (hold / parallel load / shift left / shift right). It accepts one command per handshake: an N-bit word, an operation and a shift amount. It then drives the register's select, parallel-data and serial-fill inputs cycle by cycle to load the word and apply the requested multi-position shift or rotate. It sits between a requesting FSM/CPU port and one `ShiftParallel_NBIT` instance, and reads `qout` back for rotate feedback.

---
 rtl/shift_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a ShiftParallel_NBIT universal shift register: loads a word, then shifts or rotates it m times.
// Define SHIFT_ARITH_EN to make op 01 an arithmetic right shift (sign fill) instead of a logical one.
module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [N-1:0]  cmd_data,
    input  logic [N-1:0]  qout,
    output logic          s0,
    output logic          s1,
    output logic [N-1:0]  din,
    output logic          din_left,
    output logic          din_right,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [AW-1:0] AMT_MAX = AW'(N);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_op;
    logic [AW-1:0] r_cnt;
    logic [N-1:0]  r_data;
    logic          w_accept;
    logic [AW-1:0] w_amt_clamped;
    logic          w_sra_fill;

    assign w_accept      = cmd_valid & cmd_ready;
    assign w_amt_clamped = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
    assign din           = r_data;

`ifdef SHIFT_ARITH_EN
    assign w_sra_fill = qout[N-1];
`else
    assign w_sra_fill = 1'b0;
`endif

    // State, latched command and remaining-shift counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_cnt  <= w_amt_clamped;
                r_data <= cmd_data;
            end else if (r_state == SHIFT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOAD;
            LOAD:    w_next = (r_cnt != '0) ? SHIFT : DONE;
            SHIFT:   if (r_cnt == AW'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Register select and serial fill; rotate fill comes straight from qout
    always_comb begin
        {s1, s0}  = 2'b00;
        din_left  = 1'b0;
        din_right = 1'b0;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        cmd_ready = (r_state == IDLE) & ~rst;
        case (r_state)
            LOAD: {s1, s0} = 2'b01;
            SHIFT: begin
                case (r_op)
                    OP_SLL: begin
                        {s1, s0}  = 2'b10;
                        din_right = 1'b0;
                    end
                    OP_SRL: begin
                        {s1, s0} = 2'b11;
                        din_left = w_sra_fill;
                    end
                    OP_ROL: begin
                        {s1, s0}  = 2'b10;
                        din_right = qout[N-1];
                    end
                    OP_ROR: begin
                        {s1, s0} = 2'b11;
                        din_left = qout[0];
                    end
                    default: {s1, s0} = 2'b00;
                endcase
            end
            default: {s1, s0} = 2'b00;
        endcase
    end

endmodule
